// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-approach junction with emergency preemption.
// Latency: a pending request is served on the all-red exit tick; preemption leaves green on the next clk edge.
// Backpressure: none; requests are latched in sticky pending bits until their approach is granted green.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   tick                     timebase strobe; all phase timing advances only on tick
//   req[3:0]                 approach requests (bit0=M1, bit1=M2, bit2=MT, bit3=S), level or pulse
//   emg_valid, emg_dir       emergency preemption request and target approach
//   light_M1/M2/MT/S         lamp codes: 001=green, 010=yellow, 100=red
//   phase                    0=ALLRED, 1=GREEN, 2=YELLOW
//   active_dir               approach currently (or last) served
//   emg_ack                  high while emergency green is given to emg_dir
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW    = 2,
    parameter int ALLRED    = 1,
    parameter int CW        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emg_valid,
    input  logic [1:0] emg_dir,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [1:0] phase,
    output logic [1:0] active_dir,
    output logic       emg_ack
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_GMIN = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] C_GMAX = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] C_YEL  = CW'(YELLOW - 1);
    localparam logic [CW-1:0] C_AR   = CW'(ALLRED - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_pend, w_pend_nxt;
    logic [1:0]    r_rr, w_rr_nxt;
    logic [1:0]    r_dir, w_dir_nxt;
    logic          r_emg, w_emg_nxt;    // current green was held by an emergency

    logic [3:0]    w_dir_oh;
    logic [3:0]    w_req_eff;
    logic [3:0]    w_clr;
    logic [1:0]    w_pick;
    logic [2:0]    w_lamp [4];

    // First set pending bit scanning upward from the round-robin pointer, mod 4.
    function automatic logic [1:0] f_pick(input logic [3:0] p, input logic [1:0] ptr);
        logic [1:0] idx;
        f_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (p[idx]) f_pick = idx;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ALLRED;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_rr    <= '0;
            r_dir   <= '0;
            r_emg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_rr    <= w_rr_nxt;
            r_dir   <= w_dir_nxt;
            r_emg   <= w_emg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_dir_nxt   = r_dir;
        w_emg_nxt   = r_emg;
        w_clr       = 4'b0000;
        w_dir_oh    = 4'b0001 << r_dir;
        w_pick      = f_pick(r_pend, r_rr);
        // The approach already in green does not re-queue itself.
        w_req_eff   = (r_state == ST_GREEN) ? (req & ~w_dir_oh) : req;

        case (r_state)
            ST_ALLRED: begin
                if (tick) begin
                    if (r_cnt == C_AR) begin
                        if (emg_valid) begin
                            w_state_nxt = ST_GREEN;
                            w_cnt_nxt   = '0;
                            w_dir_nxt   = emg_dir;
                            w_rr_nxt    = emg_dir + 2'd1;
                            w_clr       = 4'b0001 << emg_dir;
                            w_emg_nxt   = 1'b1;
                        end else if (r_pend != 4'b0000) begin
                            w_state_nxt = ST_GREEN;
                            w_cnt_nxt   = '0;
                            w_dir_nxt   = w_pick;
                            w_rr_nxt    = w_pick + 2'd1;
                            w_clr       = 4'b0001 << w_pick;
                            w_emg_nxt   = 1'b0;
                        end
                        // otherwise rest with cnt parked at the exit value
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_GREEN: begin
                if (emg_valid && (emg_dir != r_dir)) begin
                    // Preemption to another approach: leave now, not tick-gated.
                    w_state_nxt = ST_YELLOW;
                    w_cnt_nxt   = '0;
                    w_emg_nxt   = 1'b0;
                end else if (emg_valid) begin
                    w_emg_nxt = 1'b1;       // hold green, timer frozen
                end else if (r_emg) begin
                    if (tick) begin
                        w_state_nxt = ST_YELLOW;
                        w_cnt_nxt   = '0;
                        w_emg_nxt   = 1'b0;
                    end
                end else if (tick) begin
                    if ((r_cnt >= C_GMIN) &&
                        (((r_pend & ~w_dir_oh) != 4'b0000) || (r_cnt == C_GMAX))) begin
                        w_state_nxt = ST_YELLOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (r_cnt == C_YEL) begin
                        w_state_nxt = ST_ALLRED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ALLRED;
                w_cnt_nxt   = '0;
            end
        endcase

        // A request arriving on the grant edge of its own approach is dropped.
        w_pend_nxt = (r_pend | w_req_eff) & ~w_clr;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_lamp[i] = 3'b100;
            if (r_dir == 2'(i)) begin
                if (r_state == ST_GREEN)  w_lamp[i] = 3'b001;
                if (r_state == ST_YELLOW) w_lamp[i] = 3'b010;
            end
        end
    end

    assign light_M1   = w_lamp[0];
    assign light_M2   = w_lamp[1];
    assign light_MT   = w_lamp[2];
    assign light_S    = w_lamp[3];
    assign phase      = r_state;
    assign active_dir = r_dir;
    assign emg_ack    = (r_state == ST_GREEN) && emg_valid && (emg_dir == r_dir);

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven phase scheduler for the four-approach junction: main-1 (M1), main-2 (M2), main-turn (MT) and side (S).
- Latches per-approach vehicle requests and grants green to one approach at a time, in round-robin order.
- Enforces minimum green, maximum green, yellow and all-red clearance times; supports emergency-vehicle preemption.
- Drives the junction lamp outputs directly, replacing the fixed-cycle sequencer where detectors are fitted.

Parameters:
- GREEN_MIN, 4: minimum green length, in ticks (≥1).
- GREEN_MAX, 10: maximum green length, in ticks (≥GREEN_MIN, ≤2^CW).
- YELLOW, 2: yellow length, in ticks (≥1).
- ALLRED, 1: all-red clearance length, in ticks (≥1).
- CW, 4: width of the phase timer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe (nominally 1 Hz); all phase timing advances only on cycles with tick=1.
- req  in  4  approach requests: bit0=M1, bit1=M2, bit2=MT, bit3=S. Level or pulse.
- emg_valid  in  1  emergency preemption request (level).
- emg_dir  in  2  approach to preempt to (same index as req); sampled while emg_valid=1.
- light_M1, light_M2, light_MT, light_S  out  3 each  lamp code: 001=green, 010=yellow, 100=red.
- phase  out  2  current state: 0=ALLRED, 1=GREEN, 2=YELLOW.
- active_dir  out  2  approach currently served (or last served).
- emg_ack  out  1  high while emergency green is being given to emg_dir.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high (rst). The reset polarity and synchronicity are fixed.
- Reset values (next clk edge, regardless of tick): phase=ALLRED, cnt=0, pending=0, rr_ptr=0, active_dir=0, emg_ack=0, all lights=100.
- Reset mid-operation aborts any phase immediately.
- pending[3:0] (sticky):
  - pending[i] is set on any cycle with req[i]=1.
  - pending[i] is cleared on the edge where approach i enters GREEN.
  - req[d] is ignored while d is in GREEN.
  - req[d] is latched while d is in YELLOW or ALLRED.
- Timer:
  - cnt is zeroed on every state entry.
  - cnt increments on tick.
  - A state of length L exits on the tick where cnt==L-1, so it lasts exactly L ticks.
- ALLRED:
  - On the exit tick, if emg_valid=1: go to GREEN with d=emg_dir.
  - Otherwise, if pending≠0: go to GREEN with d = first set bit scanning from rr_ptr upward, mod 4.
  - Otherwise, rest in ALLRED: cnt holds at ALLRED-1 and demand is re-evaluated every tick.
- GREEN entry: active_dir=d, rr_ptr=d+1 mod 4, pending[d] cleared.
- GREEN, normal operation: on a tick with cnt ≥ GREEN_MIN-1, go to YELLOW if either condition holds:
  - (pending & ~onehot(d)) ≠ 0, or
  - cnt == GREEN_MAX-1.
- GREEN, preemption:
  - If emg_valid=1 and emg_dir≠d: go to YELLOW on the next clk edge. This is not tick-gated and ignores GREEN_MIN.
  - If emg_valid=1 and emg_dir==d: hold GREEN, freeze cnt, emg_ack=1.
  - When emg_valid falls after an emergency green, go to YELLOW on the next tick.
- YELLOW: lasts YELLOW ticks, then goes to ALLRED. Emergency requests do not shorten yellow or all-red.
- emg_dir change mid-emergency: treated as a new preemption under the GREEN rules above.
- Lamps (combinational from state):
  - GREEN: active approach=001, others=100.
  - YELLOW: active approach=010, others=100.
  - ALLRED: all approaches=100.
  - At most one approach is non-red in any cycle. Lights never go directly from 001 to 100.
- Simultaneous events:
  - tick and preemption on the same edge: preemption wins.
  - req[i] set and clear on the same edge (GREEN entry for i): clear wins.

Test Plan (defaults, tick=1 every cycle unless stated):
- Reset, no req for 50 cycles → phase=0, all lights=100, emg_ack=0.
- Single req[0] pulse → light_M1=001 for exactly 10 ticks, then 010 for 2 ticks, then all red; rests in ALLRED; pending=0.
- req[0] and req[2] pulsed together → M1 green 4 ticks, yellow 2, all-red 1, then MT green 10 ticks; rr_ptr=3 after MT entry.
- req=4'b1111 held → green order M1, M2, MT, S, M1 …, each green 4 ticks, always separated by 2 yellow + 1 all-red.
- M1 green at cnt=1, emg_valid=1, emg_dir=3 → M1 yellow on the next edge, 2 ticks, all-red 1, then S=001 with emg_ack=1 held for 20 ticks; drop emg_valid → S yellow on the next tick.
- tick asserted every 4th cycle, with rst pulsed mid-yellow → durations scale ×4; the first edge with rst=1 forces all lights=100 and phase=0 with no tick required.
